// File: rtl/fifo.sv
// Single-clock 8 x 24-bit synchronous FIFO with Empty/Full/AlmostEmpty/AlmostFull flags and a read-side flush.
// Optional macro FIFO_OUTREG_EN adds an output register after the read register, giving two cycles of read latency.
module fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 8,
    parameter int AE_LEVEL   = 1,
    parameter int AF_LEVEL   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic                  RPReset,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Empty,
    output logic                  Full,
    output logic                  AlmostEmpty,
    output logic                  AlmostFull
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_accept;
    logic                  rd_accept;

    // Flags decode the registered count, so acceptance always uses the pre-edge state.
    assign Empty       = (count_q == '0);
    assign Full        = (count_q == DEPTH_C);
    assign AlmostEmpty = (count_q <= AE_C);
    assign AlmostFull  = (count_q >= AF_C);

    always_comb begin
        wr_accept = WrEn && !Full && !RPReset;
        rd_accept = RdEn && !Empty && !RPReset;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (RPReset) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem[rd_ptr_q];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is never reset; a read and write never share an address in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[wr_ptr_q] <= Data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef FIFO_OUTREG_EN
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] q_out_q, q_out_d;

    // The output stage only advances behind an accepted read; a flush freezes it.
    always_comb begin
        rd_valid_d = rd_accept;
        q_out_d    = q_out_q;
        if (rd_valid_q && !RPReset) begin
            q_out_d = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            q_out_q    <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            q_out_q    <= q_out_d;
        end
    end

    assign Q = q_out_q;
`else
    assign Q = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Table-driven bench for fifo: flag expectations per step plus a read-data scoreboard.
module tb_fifo;
    localparam int DW    = 24;
    localparam int DEPTH = 8;
`ifdef FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] Data = '0;
    logic          WrEn = 1'b0;
    logic          RdEn = 1'b0;
    logic          RPReset = 1'b0;
    logic [DW-1:0] Q;
    logic          Empty, Full, AlmostEmpty, AlmostFull;

    fifo dut (
        .clk(clk), .reset(reset), .Data(Data), .WrEn(WrEn), .RdEn(RdEn),
        .RPReset(RPReset), .Q(Q), .Empty(Empty), .Full(Full),
        .AlmostEmpty(AlmostEmpty), .AlmostFull(AlmostFull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, wr, rd, rp;
        logic [DW-1:0] data;
        logic [3:0]    flags;   // {Empty, Full, AlmostEmpty, AlmostFull}
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } sb_t;

    vec_t          vecs[$];
    sb_t           sb[$];
    logic [DW-1:0] model[$];
    logic [DW-1:0] q_model = '0;
    int            step_idx = 0;
    int            tests = 0;
    int            fails = 0;

    function automatic logic [3:0] fl(input int c);
        return {c == 0, c == DEPTH, c <= 1, c >= 7};
    endfunction

    task automatic add(input logic rst, wr, rd, rp, input logic [DW-1:0] d, input int cnt);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.rp = rp; v.data = d; v.flags = fl(cnt);
        vecs.push_back(v);
    endtask

    task automatic check_flags(input logic [3:0] exp);
        logic [3:0] got;
        got = {Empty, Full, AlmostEmpty, AlmostFull};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL flags step %0d: got E/F/AE/AF=%b required %b", step_idx - 1, got, exp);
        end
    endtask

    // Drive one cycle, advance the reference queue, then retire any due scoreboard entries and check Q.
    task automatic step(input logic rst, wr, rd, rp, input logic [DW-1:0] d);
        int  n;
        sb_t e;
        reset = rst; WrEn = wr; RdEn = rd; RPReset = rp; Data = d;
        n = model.size();
        if (rst) begin
            model.delete();
            sb.delete();
            q_model = '0;
        end else if (rp) begin
            model.delete();
        end else begin
            if (rd && n > 0) begin
                e.d   = model.pop_front();
                e.due = step_idx + LAT - 1;
                sb.push_back(e);
            end
            if (wr && n < DEPTH) model.push_back(d);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due <= step_idx) begin
            e = sb.pop_front();
            q_model = e.d;
        end
        tests++;
        if (Q !== q_model) begin
            fails++;
            $display("FAIL q step %0d: got %h required %h", step_idx, Q, q_model);
        end
        $display("[TB] step %0d rst=%b wr=%b rd=%b rp=%b data=%h -> Q=%h E=%b F=%b AE=%b AF=%b",
                 step_idx, rst, wr, rd, rp, d, Q, Empty, Full, AlmostEmpty, AlmostFull);
        step_idx++;
    endtask

    initial begin
        int n;
        // reset then idle
        add(1, 0, 0, 0, 24'h0, 0);
        add(0, 0, 0, 0, 24'h0, 0);
        // fill to full, overflow write dropped, drain in order
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, DW'(i), i);
        add(0, 1, 0, 0, 24'hFFFFFF, 8);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 24'h0, 8 - i);
        // pointer wrap-around
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, DW'(8'h10 + i), i + 1);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 24'h0, 4 - i);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, DW'(8'h20 + i), i + 1);
        for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 24'h0, 5 - i);
        // full with simultaneous write and read
        for (int i = 0; i < 8; i++) add(0, 1, 0, 0, DW'(8'h30 + i), i + 1);
        add(0, 1, 1, 0, 24'h00003F, 7);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 0, 24'h0, 6 - i);
        // empty with simultaneous write and read
        add(0, 1, 1, 0, 24'hABCDEF, 1);
        add(0, 0, 1, 0, 24'h0, 0);
        // read-pointer flush with a colliding write
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, DW'(8'h40 + i), i + 1);
        add(0, 1, 0, 1, 24'h000099, 0);
        add(0, 1, 0, 0, 24'h000050, 1);
        add(0, 0, 1, 0, 24'h0, 0);
        // full reset with data stored
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, DW'(8'h60 + i), i + 1);
        add(1, 1, 1, 0, 24'h000077, 0);
        add(0, 0, 0, 0, 24'h0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].rp, vecs[i].data);
            check_flags(vecs[i].flags);
        end

        // Bounded fill until Full: it must take exactly DEPTH writes.
        n = 0;
        while (!Full && n < 20) begin
            step(0, 1, 0, 0, DW'(24'h700 + n));
            n++;
        end
        tests++;
        if (n != DEPTH) begin
            fails++;
            $display("FAIL fill_to_full: got %0d writes required %0d", n, DEPTH);
        end
        // Bounded drain until Empty, checking order through the scoreboard.
        n = 0;
        while (!Empty && n < 20) begin
            step(0, 0, 1, 0, 24'h0);
            n++;
        end
        tests++;
        if (n != DEPTH) begin
            fails++;
            $display("FAIL drain_to_empty: got %0d reads required %0d", n, DEPTH);
        end
        step(0, 0, 0, 0, 24'h0);
        step(0, 0, 0, 0, 24'h0);
        check_flags(fl(0));
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
